// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PCSrc encoding and register-address width.
package pipe_pkg;

   localparam int REG_W   = 5;
   localparam int PCSRC_W = 3;

   localparam logic [PCSRC_W-1:0] PC_SEQ = 3'd0;
   localparam logic [PCSRC_W-1:0] PC_BR  = 3'd1;
   localparam logic [PCSRC_W-1:0] PC_J   = 3'd2;
   localparam logic [PCSRC_W-1:0] PC_JR  = 3'd3;
   localparam logic [PCSRC_W-1:0] PC_INT = 3'd4;
   localparam logic [PCSRC_W-1:0] PC_EXC = 3'd5;

endpackage

// File: rtl/load_track.sv
// Load-use tracker: a short history of recent load destinations, kept
// until each load's data becomes forwardable to ID, plus the comparators
// that flag an ID source register depending on any of them.
module load_track
   import pipe_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int LREG_W   = REG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              ex_memrd,
   input  logic [LREG_W-1:0] ex_rt,
   input  logic [LREG_W-1:0] id_rs,
   input  logic [LREG_W-1:0] id_rt,
   output logic              hazard
);

   // Register 0 is hard-wired, so a dependency on it is never real.
   function automatic logic reg_hit(input logic [LREG_W-1:0] dst,
                                    input logic [LREG_W-1:0] rs,
                                    input logic [LREG_W-1:0] rt);
      return ((rs != '0) && (rs == dst)) || ((rt != '0) && (rt == dst));
   endfunction

   logic ex_hit;

   assign ex_hit = ex_memrd && reg_hit(ex_rt, id_rs, id_rt);

   genvar gi;
   generate
      if (LOAD_LAT > 1) begin : g_q
         localparam int DEPTH = LOAD_LAT - 1;

         logic [DEPTH-1:0]  vld_reg;
         logic [LREG_W-1:0] rd_reg [DEPTH];
         logic [DEPTH-1:0]  q_hit;

         // Shift the load history one slot per cycle; a flush drops every entry.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vld_reg <= '0;
               for (int k = 0; k < DEPTH; k++) rd_reg[k] <= '0;
            end else if (clr) begin
               vld_reg <= '0;
            end else begin
               vld_reg[0] <= ex_memrd;
               rd_reg[0]  <= ex_rt;
               for (int k = 1; k < DEPTH; k++) begin
                  vld_reg[k] <= vld_reg[k-1];
                  rd_reg[k]  <= rd_reg[k-1];
               end
            end
         end

         for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign q_hit[gi] = vld_reg[gi] && reg_hit(rd_reg[gi], id_rs, id_rt);
         end

         assign hazard = ex_hit || (|q_hit);
      end else begin : g_noq
         // With single-cycle latency only the load currently in EX matters.
         logic unused_noq;
         assign unused_noq = ^{clk, reset, clr};
         assign hazard     = ex_hit;
      end
   endgenerate

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard and flush controller beside ID: load-use and mult/div stalls,
// branch/jump/jr/interrupt/exception flushes, and interrupt arbitration.
module hazard_ctrl_p
   import pipe_pkg::*;
#(
   parameter int REG_W    = pipe_pkg::REG_W,
   parameter int PCSRC_W  = pipe_pkg::PCSRC_W,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PCSRC_W-1:0] id_pcsrc,
   input  logic [PCSRC_W-1:0] ex_pcsrc,
   input  logic               alu_zero,
   input  logic               id_ex_memrd,
   input  logic [REG_W-1:0]   id_ex_rt,
   input  logic [REG_W-1:0]   if_id_rs,
   input  logic [REG_W-1:0]   if_id_rt,
   input  logic               id_md_use,
   input  logic               md_start,
   input  logic               irq_req,
   input  logic               irq_en,
   output logic               stall,
   output logic               if_id_flush,
   output logic               id_ex_flush,
   output logic               ex_mem_kill,
   output logic               irq_take,
   output logic               md_busy
);

   logic       br;
   logic       jr;
   logic       jmp;
   logic       ie;
   logic       exc;
   logic       ld_haz;
   logic       md_haz;
   logic       md_issue;
   logic [5:0] cnt_reg;
   logic       irq_pend_reg;

   // Decode redirect sources and the flushes they imply.
   always_comb begin
      br          = (ex_pcsrc == PCSRC_W'(PC_BR)) && alu_zero;
      jr          = (ex_pcsrc == PCSRC_W'(PC_JR));
      jmp         = (id_pcsrc == PCSRC_W'(PC_J));
      exc         = (id_pcsrc == PCSRC_W'(PC_EXC));
      ie          = (id_pcsrc == PCSRC_W'(PC_INT)) || exc;
      if_id_flush = br || jr || jmp || ie;
      id_ex_flush = br || jr || ie;
      ex_mem_kill = ie;
   end

   load_track #(
      .LOAD_LAT (LOAD_LAT),
      .LREG_W   (REG_W)
   ) u_load_track (
      .clk      (clk),
      .reset    (reset),
      .clr      (ie),
      .ex_memrd (id_ex_memrd),
      .ex_rt    (id_ex_rt),
      .id_rs    (if_id_rs),
      .id_rt    (if_id_rt),
      .hazard   (ld_haz)
   );

   // A mult/div killed by an interrupt/exception never starts.
   assign md_issue = md_start && !ie;

   // Mult/div busy countdown; a new issue restarts the full latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (md_issue) begin
         cnt_reg <= 6'(MD_LAT);
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 6'd1;
      end
   end

   assign md_busy = (cnt_reg != '0);
   assign md_haz  = id_md_use && (md_issue || md_busy);

   // An instruction being flushed out of ID has nothing to wait for.
   assign stall = (ld_haz || md_haz) && !if_id_flush;

   // Only take the interrupt on a clean slot; exceptions in ID win.
   assign irq_take = irq_pend_reg && irq_en && !stall && !br && !jr && !jmp && !exc;

   // Latch the request pulse until taken; a new request beats the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_pend_reg <= 1'b0;
      end else if (irq_req) begin
         irq_pend_reg <= 1'b1;
      end else if (irq_take) begin
         irq_pend_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: two instances (LOAD_LAT 1 and 3) share
// stimulus; expected output vectors are queued and checked on the falling edge.
module tb_hazard_ctrl_p;
   import pipe_pkg::*;

   // Output vector order: {stall, if_id_flush, id_ex_flush, ex_mem_kill, irq_take, md_busy}
   localparam logic [5:0] S  = 6'b100000;
   localparam logic [5:0] IF = 6'b010000;
   localparam logic [5:0] IE = 6'b001000;
   localparam logic [5:0] K  = 6'b000100;
   localparam logic [5:0] T  = 6'b000010;
   localparam logic [5:0] B  = 6'b000001;
   localparam logic [5:0] Z  = 6'b000000;

   typedef struct {
      string      name;
      logic [1:0] m;
      logic [5:0] e1;
      logic [5:0] e3;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [2:0] id_pcsrc, ex_pcsrc;
   logic       alu_zero, id_ex_memrd;
   logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
   logic       id_md_use, md_start, irq_req, irq_en;

   logic stall1, iff1, ief1, kill1, take1, busy1;
   logic stall3, iff3, ief3, kill3, take3, busy3;

   exp_t sb_q[$];
   exp_t mon_it;
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_p #(.LOAD_LAT(1), .MD_LAT(4)) dut1 (
      .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .ex_pcsrc(ex_pcsrc),
      .alu_zero(alu_zero), .id_ex_memrd(id_ex_memrd), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_md_use(id_md_use),
      .md_start(md_start), .irq_req(irq_req), .irq_en(irq_en),
      .stall(stall1), .if_id_flush(iff1), .id_ex_flush(ief1),
      .ex_mem_kill(kill1), .irq_take(take1), .md_busy(busy1));

   hazard_ctrl_p #(.LOAD_LAT(3), .MD_LAT(4)) dut3 (
      .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .ex_pcsrc(ex_pcsrc),
      .alu_zero(alu_zero), .id_ex_memrd(id_ex_memrd), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_md_use(id_md_use),
      .md_start(md_start), .irq_req(irq_req), .irq_en(irq_en),
      .stall(stall3), .if_id_flush(iff3), .id_ex_flush(ief3),
      .ex_mem_kill(kill3), .irq_take(take3), .md_busy(busy3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int inst,
                        input logic [5:0] got, input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %b want %b", name, inst, got, exp);
      end else begin
         $display("ok   %s dut%0d: %b", name, inst, got);
      end
   endtask

   // Monitor: compare every vector queued for this cycle against both instances.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         mon_it = sb_q.pop_front();
         if (mon_it.m[0]) check(mon_it.name, 1, {stall1, iff1, ief1, kill1, take1, busy1}, mon_it.e1);
         if (mon_it.m[1]) check(mon_it.name, 3, {stall3, iff3, ief3, kill3, take3, busy3}, mon_it.e3);
      end
   end

   task automatic drv(input logic memrd, input logic [4:0] exrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [2:0] exp_c, input logic az,
                      input logic [2:0] idp, input logic mduse, input logic mdst,
                      input logic irq, input logic ien);
      id_ex_memrd = memrd;
      id_ex_rt    = exrt;
      if_id_rs    = rs;
      if_id_rt    = rt;
      ex_pcsrc    = exp_c;
      alu_zero    = az;
      id_pcsrc    = idp;
      id_md_use   = mduse;
      md_start    = mdst;
      irq_req     = irq;
      irq_en      = ien;
   endtask

   // Queue the expectation for the current cycle, then advance one clock.
   task automatic cyc(input string name, input logic [1:0] m,
                      input logic [5:0] e1, input logic [5:0] e3);
      exp_t it;
      it.name = name;
      it.m    = m;
      it.e1   = e1;
      it.e3   = e3;
      sb_q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      cyc("reset_idle", 2'b11, Z, Z);
      reset = 1'b0;
      cyc("idle", 2'b11, Z, Z);

      // Load-use directly behind a load: 1 cycle vs 3 cycles
      drv(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0); cyc("lw_use_c0", 2'b11, S, S);
      drv(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0); cyc("lw_use_c1", 2'b11, Z, S);
      cyc("lw_use_c2", 2'b11, Z, S);
      cyc("lw_use_c3", 2'b11, Z, Z);
      // Register 0 never matches; rt path matches
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("r0_ex", 2'b11, Z, Z);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("r0_q", 2'b11, Z, Z);
      drv(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0); cyc("lw_rt", 2'b11, S, S);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("drain", 2'b11, Z, Z);

      // One instruction of separation: LOAD_LAT-1 stall cycles
      drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("sep_c0", 2'b11, Z, Z);
      drv(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0); cyc("sep_c1", 2'b11, Z, S);
      cyc("sep_c2", 2'b11, Z, S);
      cyc("sep_c3", 2'b11, Z, Z);

      // mult/div: 5 stall cycles, busy for 4
      drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); cyc("md_c0", 2'b11, S, S);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc("md_busy", 2'b11, S | B, S | B);
      cyc("md_done", 2'b11, Z, Z);

      // Redirects override hazards
      drv(1, 3, 3, 0, 1, 1, 0, 0, 0, 0, 0); cyc("br_taken_ld", 2'b11, IF | IE, IF | IE);
      drv(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0); cyc("jr_flush", 2'b11, IF | IE, IF | IE);
      drv(0, 0, 3, 0, 0, 0, 2, 0, 0, 0, 0); cyc("j_flush", 2'b11, IF, IF);
      drv(1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0); cyc("br_not_taken", 2'b11, S, S);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("drain", 2'b11, Z, Z);

      // Interrupt deferred by a load stall
      drv(1, 4, 4, 0, 0, 0, 0, 0, 0, 1, 1); cyc("irq_ld_c0", 2'b11, S, S);
      drv(0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1); cyc("irq_ld_c1", 2'b11, T, S);
      cyc("irq_ld_c2", 2'b11, Z, S);
      cyc("irq_ld_c3", 2'b11, Z, T);
      cyc("irq_ld_c4", 2'b11, Z, Z);

      // Interrupt in ID: all flushes, load history cleared, md_start suppressed
      drv(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("ld6", 2'b11, Z, Z);
      drv(1, 6, 6, 0, 0, 0, 4, 0, 1, 0, 0); cyc("int_id", 2'b11, IF | IE | K, IF | IE | K);
      drv(0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0); cyc("int_after", 2'b11, Z, Z);

      // irq_en gating, exception priority, set beats clear
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("irq_en0_req", 2'b11, Z, Z);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("irq_en0_hold", 2'b11, Z, Z);
      drv(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1); cyc("exc_priority", 2'b11, IF | IE | K, IF | IE | K);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("take_set_wins", 2'b11, T, T);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("take_again", 2'b11, T, T);
      cyc("pend_cleared", 2'b11, Z, Z);

      // Asynchronous reset with cnt=3 and irq pending
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("md_go", 2'b11, Z, Z);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("busy_cnt4", 2'b11, B, B);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b1;
      cyc("async_rst_irq_md", 2'b11, Z, Z);
      reset = 1'b0;
      cyc("post_rst", 2'b11, Z, Z);

      // Asynchronous reset during an md stall
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("md_go2", 2'b11, Z, Z);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      reset = 1'b1;
      cyc("async_rst_stall", 2'b11, Z, Z);
      reset = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("post_rst2", 2'b11, Z, Z);

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
